// File: rtl/tracklet_div_34s_18s_seq.sv
// tracklet_div_34s_18s_seq
// Sequential radix-2 restoring divider: 34-bit signed dividend by 18-bit signed
// divisor, yielding an 18-bit signed quotient (saturating) and an exact 18-bit
// signed remainder. One quotient bit per cycle behind an ap_start/ap_done handshake.
module tracklet_div_34s_18s_seq #(
  parameter int DIVIDEND_W = 34,
  parameter int DIVISOR_W  = 18
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [DIVIDEND_W-1:0] din0,
  input  logic [DIVISOR_W-1:0]  din1,
  output logic [DIVISOR_W-1:0]  dout_q,
  output logic [DIVISOR_W-1:0]  dout_r,
  output logic                  div_by_zero,
  output logic                  ovf
);

  localparam int                  LAST_ITER = DIVIDEND_W - 1;
  localparam logic [DIVISOR_W-1:0] Q_POS_SAT = {1'b0, {(DIVISOR_W-1){1'b1}}};
  localparam logic [DIVISOR_W-1:0] Q_NEG_SAT = {1'b1, {(DIVISOR_W-1){1'b0}}};
  // Largest quotient magnitudes representable for each result sign.
  localparam logic [DIVIDEND_W-1:0] MAG_POS_MAX = DIVIDEND_W'(Q_POS_SAT);
  localparam logic [DIVIDEND_W-1:0] MAG_NEG_MAX = DIVIDEND_W'(Q_NEG_SAT);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                 r_state;
  logic [DIVIDEND_W-1:0]  r_dvd;      // dividend bits shift out, quotient bits shift in
  logic [DIVISOR_W-1:0]   r_dsr;      // |divisor|
  logic [DIVISOR_W-1:0]   r_rem;      // partial remainder, always < |divisor|
  logic [5:0]             r_cnt;
  logic                   r_sign_n;
  logic                   r_sign_d;
  logic [DIVISOR_W-1:0]   r_q;
  logic [DIVISOR_W-1:0]   r_r;
  logic                   r_dz;
  logic                   r_ovf;

  logic [DIVIDEND_W-1:0]  w_abs_n;
  logic [DIVISOR_W-1:0]   w_abs_d;
  logic [DIVISOR_W:0]     w_rem_shift;
  logic                   w_ge;
  logic [DIVISOR_W-1:0]   w_rem_sub;
  logic [DIVISOR_W-1:0]   w_rem_next;
  logic [DIVIDEND_W-1:0]  w_quo_mag;
  logic                   w_q_neg;
  logic [DIVISOR_W-1:0]   w_q_fin;
  logic [DIVISOR_W-1:0]   w_r_fin;
  logic                   w_ovf_fin;

  assign w_abs_n = din0[DIVIDEND_W-1] ? (~din0 + DIVIDEND_W'(1)) : din0;
  assign w_abs_d = din1[DIVISOR_W-1]  ? (~din1 + DIVISOR_W'(1))  : din1;

  // One restoring step: the shifted remainder is 19 bits wide, but after a
  // successful subtract the result is below |divisor|, so the low 18 bits of
  // the difference are exact even though the subtract itself wraps.
  assign w_rem_shift = {r_rem, r_dvd[DIVIDEND_W-1]};
  assign w_ge        = w_rem_shift >= {1'b0, r_dsr};
  assign w_rem_sub   = w_rem_shift[DIVISOR_W-1:0] - r_dsr;
  assign w_rem_next  = w_ge ? w_rem_sub : w_rem_shift[DIVISOR_W-1:0];
  assign w_quo_mag   = {r_dvd[DIVIDEND_W-2:0], w_ge};
  assign w_q_neg     = r_sign_n ^ r_sign_d;

  // Apply signs and saturation to the final magnitudes of the last iteration.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_q_fin   = w_quo_mag[DIVISOR_W-1:0];
    w_ovf_fin = 1'b0;
    if (!w_q_neg) begin
      if (w_quo_mag > MAG_POS_MAX) begin
        w_q_fin   = Q_POS_SAT;
        w_ovf_fin = 1'b1;
      end
    end else begin
      if (w_quo_mag > MAG_NEG_MAX) begin
        w_q_fin   = Q_NEG_SAT;
        w_ovf_fin = 1'b1;
      end else begin
        w_q_fin = ~w_quo_mag[DIVISOR_W-1:0] + DIVISOR_W'(1);
      end
    end
    w_r_fin = r_sign_n ? (~w_rem_next + DIVISOR_W'(1)) : w_rem_next;
  end

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      // NOTE: only control state and visible outputs are reset; the datapath
      // registers are always loaded on capture before they are read.
      r_state <= S_IDLE;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      unique case (r_state)
        S_IDLE: begin
          if (ap_start) begin
            r_dvd    <= w_abs_n;
            r_dsr    <= w_abs_d;
            r_sign_n <= din0[DIVIDEND_W-1];
            r_sign_d <= din1[DIVISOR_W-1];
            r_rem    <= '0;
            r_cnt    <= '0;
            if (din1 == '0) begin
              r_q     <= din0[DIVIDEND_W-1] ? Q_NEG_SAT : Q_POS_SAT;
              r_r     <= '0;
              r_dz    <= 1'b1;
              r_ovf   <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_dvd <= w_quo_mag;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'(LAST_ITER)) begin
            r_q     <= w_q_fin;
            r_r     <= w_r_fin;
            r_dz    <= 1'b0;
            r_ovf   <= w_ovf_fin;
            r_state <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ap_ready    = (r_state == S_IDLE) && ap_start;
  assign ap_idle     = (r_state == S_IDLE);
  assign ap_done     = (r_state == S_DONE);
  assign dout_q      = r_q;
  assign dout_r      = r_r;
  assign div_by_zero = r_dz;
  assign ovf         = r_ovf;

endmodule

// File: tb/tb_tracklet_div_34s_18s_seq.sv
// Directed and back-to-back stimulus for tracklet_div_34s_18s_seq.
module tb_tracklet_div_34s_18s_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_idle;
  logic        ap_done;
  logic [33:0] din0;
  logic [17:0] din1;
  logic [17:0] dout_q;
  logic [17:0] dout_r;
  logic        div_by_zero;
  logic        ovf;

  int n_total = 0;
  int n_bad   = 0;

  tracklet_div_34s_18s_seq #(.DIVIDEND_W(34), .DIVISOR_W(18)) dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .din0        (din0),
    .din1        (din1),
    .dout_q      (dout_q),
    .dout_r      (dout_r),
    .div_by_zero (div_by_zero),
    .ovf         (ovf)
  );

  always #5 ap_clk = ~ap_clk;

  // Advance to just after the next rising edge; all driving and sampling happen there.
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: C-style truncating division followed by quotient saturation.
  function automatic void model(input logic [33:0] a, input logic [17:0] b,
                                output logic [17:0] q, output logic [17:0] r,
                                output logic dz, output logic ov);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    ov = 1'b0;
    if (sb == 0) begin
      q  = (sa < 0) ? 18'h20000 : 18'h1FFFF;
      r  = '0;
      dz = 1'b1;
    end else begin
      lq = sa / sb;
      lr = sa % sb;
      r  = lr[17:0];
      if (lq > 131071) begin
        q  = 18'h1FFFF;
        ov = 1'b1;
      end else if (lq < -131072) begin
        q  = 18'h20000;
        ov = 1'b1;
      end else begin
        q = lq[17:0];
      end
    end
  endfunction

  task automatic scramble_inputs();
    logic [31:0] r1, r2;
    r1   = $urandom;
    r2   = $urandom;
    din0 = {r2[1:0], r1};
    din1 = r2[31:14];
  endtask

  // Issue one operation from IDLE and check handshake timing and results.
  task automatic run_op(input string tag, input logic [33:0] a, input logic [17:0] b,
                        input int exp_lat, input logic signed [17:0] eq,
                        input logic signed [17:0] er, input logic edz, input logic eov);
    int lat;
    din0     = a;
    din1     = b;
    ap_start = 1'b1;
    #1;
    check({tag, " ready"}, ap_ready, 1);
    tick();
    ap_start = 1'b0;
    scramble_inputs();
    check({tag, " idle_drop"}, ap_idle, 0);
    lat = 1;
    while (!ap_done && lat < 60) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " q"}, $signed(dout_q), eq);
    check({tag, " r"}, $signed(dout_r), er);
    check({tag, " dz"}, div_by_zero, edz);
    check({tag, " ovf"}, ovf, eov);
    tick();
    check({tag, " done_pulse"}, ap_done, 0);
    check({tag, " idle_back"}, ap_idle, 1);
  endtask

  initial begin
    int          done_seen;
    int          ops, cyc, last_ready;
    logic [33:0] sa;
    logic [17:0] sb, mq, mr;
    logic        mdz, movf;
    logic [31:0] r1, r2, r3, r4;

    ap_rst   = 1'b1;
    ap_start = 1'b0;
    din0     = '0;
    din1     = '0;
    repeat (3) tick();
    check("rst idle", ap_idle, 1);
    check("rst done", ap_done, 0);
    check("rst ready", ap_ready, 0);
    check("rst q", dout_q, 0);
    check("rst r", dout_r, 0);
    check("rst dz", div_by_zero, 0);
    check("rst ovf", ovf, 0);
    ap_rst = 1'b0;
    tick();
    check("post_rst idle", ap_idle, 1);

    run_op("7/-2",       34'sd7,             -18'sd2,      35, -18'sd3,      18'sd1,     1'b0, 1'b0);
    run_op("-7/2",       -34'sd7,            18'sd2,       35, -18'sd3,      -18'sd1,    1'b0, 1'b0);
    run_op("-1e6/-1000", -34'sd1000000,      -18'sd1000,   35, 18'sd1000,    18'sd0,     1'b0, 1'b0);
    run_op("max/65536",  34'h1_FFFF_FFFF,    18'sd65536,   35, 18'sd131071,  18'sd65535, 1'b0, 1'b0);
    run_op("max/1",      34'h1_FFFF_FFFF,    18'sd1,       35, 18'sd131071,  18'sd0,     1'b0, 1'b1);
    run_op("min/-1",     34'h2_0000_0000,    -18'sd1,      35, 18'sd131071,  18'sd0,     1'b0, 1'b1);
    run_op("min/65536",  34'h2_0000_0000,    18'sd65536,   35, -18'sd131072, 18'sd0,     1'b0, 1'b0);
    run_op("min/min",    34'h2_0000_0000,    18'h20000,    35, 18'sd65536,   18'sd0,     1'b0, 1'b0);
    run_op("-5/0",       -34'sd5,            18'sd0,       1,  -18'sd131072, 18'sd0,     1'b1, 1'b0);
    run_op("0/0",        34'sd0,             18'sd0,       1,  18'sd131071,  18'sd0,     1'b1, 1'b0);
    run_op("10/3",       34'sd10,            18'sd3,       35, 18'sd3,       18'sd1,     1'b0, 1'b0);

    // Results hold while idle with inputs wiggling.
    repeat (5) begin
      scramble_inputs();
      tick();
    end
    check("hold q", dout_q, 3);
    check("hold r", dout_r, 1);

    // Abort mid-calculation: reset sampled at the end of cycle c+10.
    din0     = 34'sd1000;
    din1     = 18'sd3;
    ap_start = 1'b1;
    #1;
    check("abort ready", ap_ready, 1);
    tick();
    ap_start = 1'b0;
    repeat (9) tick();
    ap_rst = 1'b1;
    tick();
    check("abort idle", ap_idle, 1);
    check("abort q", dout_q, 0);
    check("abort r", dout_r, 0);
    ap_rst    = 1'b0;
    done_seen = 0;
    repeat (40) begin
      tick();
      if (ap_done) done_seen++;
    end
    check("abort no_done", done_seen, 0);
    run_op("100/7", 34'sd100, 18'sd7, 35, 18'sd14, 18'sd2, 1'b0, 1'b0);

    // Back-to-back with ap_start held and operands changing every cycle.
    ops        = 0;
    cyc        = 0;
    last_ready = -1;
    sa         = '0;
    sb         = '0;
    ap_start   = 1'b1;
    while (ops < 1000 && cyc < 1000 * 36 + 200) begin
      r1 = $urandom;
      r2 = $urandom;
      r3 = $urandom;
      r4 = $urandom;
      din0 = r3[0] ? {r2[1:0], r1} : {{14{r1[19]}}, r1[19:0]};
      din1 = r3[1] ? r4[17:0] : {{8{r4[9]}}, r4[9:0]};
      if (din1 == '0) din1 = 18'sd1;
      #1;
      if (ap_done) begin
        model(sa, sb, mq, mr, mdz, movf);
        check("b2b q", dout_q, mq);
        check("b2b r", dout_r, mr);
        check("b2b dz", div_by_zero, mdz);
        check("b2b ovf", ovf, movf);
        ops++;
      end
      if (ap_ready) begin
        if (last_ready >= 0) check("b2b period", cyc - last_ready, 36);
        last_ready = cyc;
        sa = din0;
        sb = din1;
      end
      tick();
      cyc++;
    end
    ap_start = 1'b0;
    check("b2b ops_completed", ops, 1000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
